// File: rtl/smpu_pkg.sv
// Shared SMPU definitions: register offsets, CTRL/STATUS bit indices, entry field layout
// (also used by the comparator stage) and the entry write-sanitising helper.
package smpu_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [7:0] OFF_ENTRY0    = 8'h00;
    localparam logic [7:0] OFF_CTRL      = 8'h20;
    localparam logic [7:0] OFF_STATUS    = 8'h24;
    localparam logic [7:0] OFF_VIOL_ADDR = 8'h28;

    localparam int CTRL_GLB_EN_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_LOCK_BIT   = 31;

    localparam int STATUS_VALID_BIT = 0;
    localparam int STATUS_OVF_BIT   = 1;

    localparam int ENTRY_BASE_MSB = 31;
    localparam int ENTRY_BASE_LSB = 9;
    localparam int ENTRY_RSVD_MSB = 8;
    localparam int ENTRY_RSVD_LSB = 5;
    localparam int ENTRY_SIZE_MSB = 4;
    localparam int ENTRY_SIZE_LSB = 1;
    localparam int ENTRY_EN_BIT   = 0;

    localparam logic [3:0] SIZE_CODE_LO  = 4'b0111;
    localparam logic [3:0] SIZE_CODE_MID = 4'b1000;
    localparam logic [3:0] SIZE_CODE_HI  = 4'b1001;

    function automatic logic size_code_legal(input logic [3:0] code);
        return (code == SIZE_CODE_LO) || (code == SIZE_CODE_MID) || (code == SIZE_CODE_HI);
    endfunction

    // Reserved bits read as zero; an illegal size code is kept but can never be enabled.
    function automatic logic [31:0] entry_sanitize(input logic [31:0] wd);
        logic [31:0] e;
        e = wd;
        e[ENTRY_RSVD_MSB:ENTRY_RSVD_LSB] = '0;
        e[ENTRY_EN_BIT] = wd[ENTRY_EN_BIT] & size_code_legal(wd[ENTRY_SIZE_MSB:ENTRY_SIZE_LSB]);
        return e;
    endfunction

endpackage

// File: rtl/smpu_cfg_regs_if.sv
// AHB-lite configuration port of the SMPU register bank.
interface smpu_cfg_regs_if;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [7:0]  haddr;
    logic        hready;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready_resp;
    logic [1:0]  hresp;

    modport master (
        output hsel, htrans, hwrite, hsize, haddr, hready, hwdata,
        input  hrdata, hready_resp, hresp
    );

    modport slave (
        input  hsel, htrans, hwrite, hsize, haddr, hready, hwdata,
        output hrdata, hready_resp, hresp
    );
endinterface

// File: rtl/smpu_viol_capture.sv
// First-deny capture: valid flag, overflow flag and the denied address, with W1C clear.
module smpu_viol_capture (
    input  logic        clk,
    input  logic        rst,
    input  logic        deny,
    input  logic [31:0] deny_addr,
    input  logic        w1c_en,
    input  logic [1:0]  w1c_data,
    output logic        viol_valid,
    output logic        viol_overflow,
    output logic [31:0] viol_addr
);
    logic clr_valid;
    logic clr_ovf;
    logic valid_eff;

    // A same-cycle clear of valid counts as already cleared, so a coincident deny re-captures.
    assign clr_valid = w1c_en & w1c_data[0];
    assign clr_ovf   = w1c_en & w1c_data[1];
    assign valid_eff = viol_valid & ~clr_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol_valid    <= 1'b0;
            viol_overflow <= 1'b0;
            viol_addr     <= '0;
        end else begin
            viol_valid    <= valid_eff | deny;
            viol_overflow <= (viol_overflow & ~clr_ovf) | (deny & valid_eff);
            if (deny && !valid_eff)
                viol_addr <= deny_addr;
        end
    end
endmodule

// File: rtl/smpu_cfg_regs.sv
// AHB-lite register bank for SMPU region entries, control and violation status.
// Define SMPU_VIOL_CAPTURE_EN to build STATUS, VIOL_ADDR, CTRL.irq_en and smpu_irq.
module smpu_cfg_regs
    import smpu_pkg::*;
#(
    parameter int ENTRY_NUM = 8
) (
    input  logic                      hclk,
    input  logic                      hrst,
    smpu_cfg_regs_if.slave            cfg,
    output logic [32*ENTRY_NUM-1:0]   smpu_entry_flat,
    output logic                      smpu_glb_en,
    input  logic                      smpu_deny,
    input  logic [31:0]               smpu_deny_addr,
    output logic                      smpu_irq
);
    logic        vld_p1;
    logic [7:0]  addr_p1;
    logic        write_p1;
    logic        word_p1;
    logic        wr_en;
    logic        lock_q;
    logic        glb_en_q;
    logic [31:0] entry_q [ENTRY_NUM];
    logic [31:0] rdata;

    // Address phase -> data phase
    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            vld_p1   <= 1'b0;
            addr_p1  <= '0;
            write_p1 <= 1'b0;
            word_p1  <= 1'b0;
        end else if (cfg.hready) begin
            vld_p1   <= cfg.hsel & cfg.htrans[1];
            addr_p1  <= cfg.haddr;
            write_p1 <= cfg.hwrite;
            word_p1  <= (cfg.hsize == HSIZE_WORD);
        end
    end

    // Data phase commit
    assign wr_en = vld_p1 & write_p1 & word_p1;

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            for (int i = 0; i < ENTRY_NUM; i++)
                entry_q[i] <= '0;
        end else if (wr_en && !lock_q) begin
            for (int i = 0; i < ENTRY_NUM; i++)
                if (addr_p1 == OFF_ENTRY0 + 8'(4 * i))
                    entry_q[i] <= entry_sanitize(cfg.hwdata);
        end
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            glb_en_q <= 1'b0;
            lock_q   <= 1'b0;
        end else if (wr_en && !lock_q && addr_p1 == OFF_CTRL) begin
            glb_en_q <= cfg.hwdata[CTRL_GLB_EN_BIT];
            lock_q   <= cfg.hwdata[CTRL_LOCK_BIT];
        end
    end

`ifdef SMPU_VIOL_CAPTURE_EN
    logic        irq_en_q;
    logic        viol_valid;
    logic        viol_overflow;
    logic [31:0] viol_addr;

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst)
            irq_en_q <= 1'b0;
        else if (wr_en && !lock_q && addr_p1 == OFF_CTRL)
            irq_en_q <= cfg.hwdata[CTRL_IRQ_EN_BIT];
    end

    smpu_viol_capture u_viol_capture (
        .clk           (hclk),
        .rst           (hrst),
        .deny          (smpu_deny),
        .deny_addr     (smpu_deny_addr),
        .w1c_en        (wr_en && addr_p1 == OFF_STATUS),
        .w1c_data      (cfg.hwdata[1:0]),
        .viol_valid    (viol_valid),
        .viol_overflow (viol_overflow),
        .viol_addr     (viol_addr)
    );

    assign smpu_irq = viol_valid & irq_en_q;
    logic unused_sig;
    assign unused_sig = &{1'b0, cfg.htrans[0]};
`else
    logic irq_en_q;
    assign irq_en_q = 1'b0;
    assign smpu_irq = 1'b0;
    logic unused_sig;
    assign unused_sig = &{1'b0, cfg.htrans[0], smpu_deny, smpu_deny_addr};
`endif

    always_comb begin
        rdata = '0;
        if (vld_p1 && !write_p1) begin
            for (int i = 0; i < ENTRY_NUM; i++)
                if (addr_p1 == OFF_ENTRY0 + 8'(4 * i))
                    rdata = entry_q[i];
            if (addr_p1 == OFF_CTRL) begin
                rdata[CTRL_GLB_EN_BIT] = glb_en_q;
                rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
                rdata[CTRL_LOCK_BIT]   = lock_q;
            end
`ifdef SMPU_VIOL_CAPTURE_EN
            if (addr_p1 == OFF_STATUS) begin
                rdata[STATUS_VALID_BIT] = viol_valid;
                rdata[STATUS_OVF_BIT]   = viol_overflow;
            end
            if (addr_p1 == OFF_VIOL_ADDR)
                rdata = viol_addr;
`endif
        end
    end

    assign cfg.hrdata      = rdata;
    assign cfg.hready_resp = 1'b1;
    assign cfg.hresp       = 2'b00;
    assign smpu_glb_en     = glb_en_q;

    for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_flat
        assign smpu_entry_flat[32*i +: 32] = entry_q[i];
    end
endmodule
